// File: rtl/mac_acc_3b.sv
// mac_acc_3b: frame multiply-accumulate of 3-bit operand pairs with a valid/ready result handshake
module mac_acc_3b #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_a,
  input  logic [2:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d, oovf_q, oovf_d;
  logic [5:0]       prod;
  logic [ACC_W:0]   add;
  logic             fire, last;
  assign prod      = {3'b000, in_a} * {3'b000, in_b};
  assign add       = {1'b0, acc_q} + {{(ACC_W-5){1'b0}}, prod};
  assign in_ready  = (state_q == ACCUM) & ~rst;
  assign out_valid = state_q == HOLD;
  assign fire      = in_valid & in_ready;
  assign last      = cnt_q == 8'(N_TERMS - 1);
  assign out_sum   = sum_q;
  assign out_ovf   = oovf_q;
  assign busy      = cnt_q != 8'd0;
  // next state: accumulate beats, close the frame on the last one, release on out_ready
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    oovf_d  = oovf_q;
    if (fire && last) begin
      sum_d   = add[ACC_W-1:0];
      oovf_d  = ovf_q | add[ACC_W];
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = HOLD;
    end else if (fire) begin
      acc_d = add[ACC_W-1:0];
      cnt_d = cnt_q + 8'd1;
      ovf_d = ovf_q | add[ACC_W];
    end
    if (state_q == HOLD && out_ready) state_d = ACCUM;
  end
  // state registers, cleared asynchronously so partial frames and pending results are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      oovf_q  <= oovf_d;
    end
  end
endmodule

// File: tb/tb_mac_acc_3b.sv
// tb_mac_acc_3b: three configurations of mac_acc_3b checked every cycle against a frame-level model
module tb_mac_acc_3b;
  logic       clk, rst;
  logic       iv[3], ir[3], ov[3], of[3], bz[3], ordy[3];
  logic [2:0] ia[3], ib[3];
  logic [9:0] s0, s2;
  logic [5:0] s1;
  logic [31:0] as_[3];
  int n_cmp = 0, n_bad = 0;
  int nt[3] = '{4, 2, 1};
  int aw[3] = '{10, 6, 10};
  bit    m_hold[3], m_ovf[3];
  int    m_cnt[3], m_sum[3];
  longint m_tot[3];

  assign as_[0] = {22'b0, s0};
  assign as_[1] = {26'b0, s1};
  assign as_[2] = {22'b0, s2};

  mac_acc_3b d0 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]), .in_b(ib[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(s0), .out_ovf(of[0]), .busy(bz[0]));
  mac_acc_3b #(.N_TERMS(2), .ACC_W(6)) d1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(ia[1]), .in_b(ib[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(s1), .out_ovf(of[1]), .busy(bz[1]));
  mac_acc_3b #(.N_TERMS(1), .ACC_W(10)) d2 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_a(ia[2]), .in_b(ib[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(s2), .out_ovf(of[2]), .busy(bz[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  function automatic longint pr(int d);
    return longint'(ia[d]) * longint'(ib[d]);
  endfunction

  // frame-level model: a frame result is the plain total of its products, wrapped; overflow iff total >= 2^W
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_hold[d] <= 1'b0;
        m_cnt[d]  <= 0;
        m_tot[d]  <= 0;
        m_sum[d]  <= 0;
        m_ovf[d]  <= 1'b0;
      end else if (m_hold[d]) begin
        if (ordy[d]) m_hold[d] <= 1'b0;
      end else if (iv[d]) begin
        if (m_cnt[d] + 1 == nt[d]) begin
          m_sum[d]  <= int'((m_tot[d] + pr(d)) % (64'sd1 << aw[d]));
          m_ovf[d]  <= (m_tot[d] + pr(d)) >= (64'sd1 << aw[d]);
          m_tot[d]  <= 0;
          m_cnt[d]  <= 0;
          m_hold[d] <= 1'b1;
        end else begin
          m_tot[d] <= m_tot[d] + pr(d);
          m_cnt[d] <= m_cnt[d] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("in_ready[%0d]", d), {31'b0, ir[d]}, {31'b0, !m_hold[d] && !rst});
      chk($sformatf("out_valid[%0d]", d), {31'b0, ov[d]}, {31'b0, m_hold[d]});
      chk($sformatf("busy[%0d]", d), {31'b0, bz[d]}, {31'b0, m_cnt[d] != 0});
      chk($sformatf("out_sum[%0d]", d), as_[d], m_sum[d]);
      chk($sformatf("out_ovf[%0d]", d), {31'b0, of[d]}, {31'b0, m_ovf[d]});
    end
  end

  task automatic send(int d, logic [2:0] a, logic [2:0] b);
    logic acc;
    int n = 0;
    iv[d] = 1'b1;
    ia[d] = a;
    ib[d] = b;
    do begin
      @(negedge clk);
      acc = ir[d];
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout[%0d]: in_ready never 1 within 50 cycles", d);
    end
  endtask

  initial begin
    logic [2:0] ga[4], gb[4];
    int held;
    ga = '{3'd0, 3'd5, 3'd3, 3'd1};
    gb = '{3'd7, 3'd0, 3'd2, 3'd6};
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ia[d] = 3'd0; ib[d] = 3'd0; ordy[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, ir[0]}, 0);
    chk("rst_out_sum", as_[0], 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, ir[0]}, 1);
    @(posedge clk); #1;
    repeat (4) send(0, 3'd7, 3'd7);
    iv[0] = 1'b0;
    @(negedge clk);
    chk("def_latency_valid", {31'b0, ov[0]}, 1);
    chk("def_sum", as_[0], 196);
    chk("def_ovf", {31'b0, of[0]}, 0);
    @(posedge clk); #1;
    send(1, 3'd7, 3'd7); send(1, 3'd7, 3'd7);
    iv[1] = 1'b0;
    @(negedge clk);
    chk("w6_sum", as_[1], 34);
    chk("w6_ovf", {31'b0, of[1]}, 1);
    @(posedge clk); #1;
    send(1, 3'd1, 3'd1); send(1, 3'd1, 3'd1);
    iv[1] = 1'b0;
    @(negedge clk);
    chk("w6_sum2", as_[1], 2);
    chk("w6_ovf2", {31'b0, of[1]}, 0);
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    repeat (4) send(0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    held = m_sum[0];
    repeat (5) begin
      iv[0] = 1'b1; ia[0] = 3'($urandom_range(0, 7)); ib[0] = 3'($urandom_range(0, 7));
      @(negedge clk);
      chk("bp_valid", {31'b0, ov[0]}, 1);
      chk("bp_ready", {31'b0, ir[0]}, 0);
      chk("bp_sum_stable", as_[0], held);
      @(posedge clk); #1;
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp_release_valid", {31'b0, ov[0]}, 0);
    chk("bp_release_ready", {31'b0, ir[0]}, 1);
    chk("bp_no_consume", {31'b0, bz[0]}, 0);
    @(posedge clk); #1;
    send(0, 3'd5, 3'd5); send(0, 3'd5, 3'd5);
    iv[0] = 1'b0;
    #2 rst = 1'b1;
    #4 rst = 1'b0;
    @(posedge clk); #1;
    repeat (4) send(0, 3'd1, 3'd1);
    iv[0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_sum", as_[0], 4);
    chk("rst_mid_ovf", {31'b0, of[0]}, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      send(0, ga[i], gb[i]);
      iv[0] = 1'b0;
      if (i == 0) begin
        @(negedge clk);
        chk("gap_busy", {31'b0, bz[0]}, 1);
      end
      if (i < 3) begin
        repeat (3) @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    chk("gap_sum", as_[0], 12);
    chk("gap_busy_end", {31'b0, bz[0]}, 0);
    @(posedge clk); #1;
    iv[2] = 1'b1; ia[2] = 3'd2; ib[2] = 3'd3;
    @(posedge clk); #1;
    ia[2] = 3'd4; ib[2] = 3'd4;
    @(negedge clk);
    chk("n1_sum1", as_[2], 6);
    chk("n1_ready_low", {31'b0, ir[2]}, 0);
    @(negedge clk);
    chk("n1_ready_high", {31'b0, ir[2]}, 1);
    @(negedge clk);
    chk("n1_sum2", as_[2], 16);
    chk("n1_ready_low2", {31'b0, ir[2]}, 0);
    @(posedge clk); #1;
    iv[2] = 1'b0;
    repeat (1500) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        iv[d]   = 1'($urandom_range(0, 1));
        ordy[d] = $urandom_range(0, 3) != 0;
        ia[d]   = 3'($urandom_range(0, 7));
        ib[d]   = 3'($urandom_range(0, 7));
      end
    end
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mac_acc_3b.md
MAC_ACC_3B -- requirements
Module: mac_acc_3b

Interface
REQ-001 The module SHALL have parameter N_TERMS, default 4, the number of products summed per frame; legal range 1..255.
REQ-002 The module SHALL have parameter ACC_W, default 10, the accumulator and result width; legal range 6..32.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: the reset, asynchronous and active-high.
REQ-005 Port in_valid, input, 1: operand pair in_a/in_b is valid this cycle.
REQ-006 Port in_ready, output, 1: the block accepts an operand pair this cycle.
REQ-007 Port in_a, input, 3: unsigned multiplicand.
REQ-008 Port in_b, input, 3: unsigned multiplier.
REQ-009 Port out_valid, output, 1: out_sum/out_ovf hold a completed frame result.
REQ-010 Port out_ready, input, 1: the consumer takes the result this cycle.
REQ-011 Port out_sum, output, ACC_W: the frame sum of products, modulo 2^ACC_W.
REQ-012 Port out_ovf, output, 1: at least one carry out of ACC_W bits occurred during the frame.
REQ-013 Port busy, output, 1: at least one beat of the current frame has been accepted (cnt != 0).

Function
REQ-014 An input beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; no other edge SHALL change acc or cnt.
REQ-015 The product SHALL be the full unsigned 6-bit in_a*in_b (range 0..49), zero-extended to ACC_W bits before addition.
REQ-016 The block SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-017 In ACCUM, an accepted beat with cnt < N_TERMS-1 SHALL set acc <= acc + product and cnt <= cnt + 1, and SHALL set the internal ovf flag if the (ACC_W+1)-bit sum has its MSB set.
REQ-018 In ACCUM, an accepted beat with cnt == N_TERMS-1 SHALL load out_sum <= (acc + product) mod 2^ACC_W, load out_ovf <= ovf OR carry of this addition, clear acc, cnt and ovf to 0, and enter HOLD.
REQ-019 Latency: out_valid SHALL assert on the first rising edge after the last beat of a frame is accepted.
REQ-020 In HOLD, out_sum and out_ovf SHALL stay stable and in_valid SHALL be ignored.
REQ-021 In HOLD, a rising edge with out_ready=1 SHALL return the block to ACCUM, deasserting out_valid and reasserting in_ready on that edge.
REQ-022 In HOLD with out_ready=0, the block SHALL stay in HOLD indefinitely.
REQ-023 in_ready and out_valid SHALL be decoded from registered state only, with no combinational path from in_valid or out_ready.
REQ-024 With N_TERMS=1, every accepted beat SHALL produce a result; sustained throughput is one result per two cycles.
REQ-025 Idle cycles (in_valid=0) inside a frame SHALL not change acc, cnt or ovf.
REQ-026 out_sum and out_ovf SHALL retain the last frame's values after the return to ACCUM, until the next frame completes.

Reset
REQ-027 While rst=1, the block SHALL force state=ACCUM, acc=0, cnt=0, ovf=0, out_sum=0, out_ovf=0, out_valid=0, busy=0 and in_ready=0, asynchronously.
REQ-028 When rst asserts mid-frame or in HOLD, partial sums and undelivered results SHALL be discarded.
REQ-029 After rst deasserts, in_ready SHALL read 1 and the next accepted beat SHALL be beat 0 of a new frame.

Verification
REQ-030 Defaults: four beats of (7,7) back-to-back -> out_valid one cycle after the 4th beat, out_sum=196, out_ovf=0.
REQ-031 ACC_W=6, N_TERMS=2: beats (7,7),(7,7) -> out_sum=34 (98 mod 64), out_ovf=1; the next frame of (1,1),(1,1) -> out_sum=2, out_ovf=0.
REQ-032 Backpressure: complete a frame, hold out_ready=0 for 5 cycles while driving in_valid=1 -> out_valid=1, in_ready=0 and out_sum stable throughout, no beats consumed; out_ready=1 -> out_valid=0 and in_ready=1 on the next edge.
REQ-033 Reset mid-frame: accept (5,5),(5,5), pulse rst, then send four beats of (1,1) -> out_sum=4, out_ovf=0.
REQ-034 Gaps and zeros: beats (0,7),(5,0),(3,2),(1,6), with 3 idle cycles between each pair -> out_sum=12, busy high from the 1st accept until out_valid rises.
REQ-035 N_TERMS=1: stream (2,3),(4,4) -> results 6 then 16, with in_ready alternating 1,0 each cycle.
